reg_serializer: RTL and testbench
=================================

// Module: reg_serializer
// PURPOSE
// - Read-out side of the parameterised register: takes a WIDTH-bit register value and shifts it out serially.
// - Uses a valid/ready load handshake and a programmable bit period.
// - Sits between a register output and a slow serial sink (debug/output port).
// - Holds one word at a time; no buffering beyond the shift register.
// PARAMETERS
// - WIDTH      16  word width in bits, >= 2
// - CLK_DIV    4   CLK cycles per serial bit, >= 1
// - MSB_FIRST  1   1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
// PORTS
// - CLK         in   1      clock, rising edge
// - RST_N       in   1      reset, asynchronous, active-low
// - data_in     in   WIDTH  word to transmit; sampled only on handshake
// - load_valid  in   1      source offers data_in
// - load_ready  out  1      serializer accepts a word (high only in IDLE)
// - ser_out     out  1      serial data; 0 when not framing
// - ser_en      out  1      high while a frame is on ser_out
// - bit_strobe  out  1      one-cycle pulse in the first cycle of each bit
// - done        out  1      one-cycle pulse after the last bit
// BEHAVIOUR
// - Reset (async assert, sync deassert by user): state=IDLE, shift reg=0, counters=0.
//   Output reset values: load_ready=1, ser_out=0, ser_en=0, bit_strobe=0, done=0.
// - States: IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE: load_ready=1.
//   Handshake = load_valid & load_ready at edge t: capture data_in, div_cnt=0, bit_cnt=0, go SHIFT.
// - SHIFT, starting t+1: ser_en=1; ser_out = current bit; each bit held exactly CLK_DIV cycles.
//   - bit_strobe=1 when div_cnt==0.
//   - When div_cnt==CLK_DIV-1: div_cnt wraps to 0, shift reg advances one bit, bit_cnt++.
//   - Shift direction set by MSB_FIRST; vacated bit fills with 0.
//   - After bit_cnt==WIDTH-1 completes its period -> DONE.
//   - Frame occupies cycles t+1 .. t+WIDTH*CLK_DIV.
// - DONE (cycle t+WIDTH*CLK_DIV+1): done=1, ser_en=0, ser_out=0, load_ready=0; next state IDLE.
// - Next handshake is possible at t+WIDTH*CLK_DIV+2 at the earliest (load_ready back high).
// - load_valid while SHIFT/DONE: ignored. data_in changes after capture: no effect on the frame.
// - CLK_DIV=1: bit_strobe high every SHIFT cycle; div_cnt constant 0.
// - Counter widths: bit_cnt $clog2(WIDTH); div_cnt max(1,$clog2(CLK_DIV)). No overflow past terminal values.
// - RST_N low mid-frame: immediate abort, all outputs to reset values; the partial word is lost.
// - All outputs registered or decoded from state only; no combinational path load_valid -> load_ready.
// STRUCTURE
// - Shared package: state encoding localparams (IDLE/SHIFT/DONE), clog2-with-min-1 helper.
// - Sub-module bit_tick_gen: div counter producing bit_strobe and end-of-bit tick, with sync clear.
// - Top level holds FSM, shift register and bit counter.
// TESTING (WIDTH=16, CLK_DIV=4 unless stated)
// - Reset, idle 10 cycles -> load_ready=1, ser_out=0, ser_en=0, no strobes.
// - MSB_FIRST=1, data_in=16'hA5C3, handshake at t.
//   -> ser_out = 1010_0101_1100_0011, 4 cycles per bit, from t+1.
//   -> 16 bit_strobes at t+1+4k; done at t+65; load_ready=1 at t+66.
// - MSB_FIRST=0, data_in=16'h0001 -> ser_out=1 for t+1..t+4, then 0; ser_en high 64 cycles.
// - load_valid held high, data_in changed during frame.
//   -> first word sent intact; second capture at t+66; ser_en gap of 2 cycles between frames.
// - CLK_DIV=1, WIDTH=8, data_in=8'hFF -> ser_out=1 for t+1..t+8; bit_strobe every cycle; done at t+9.
// - RST_N low at t+20 mid-frame, released at t+23.
//   -> ser_en=0, ser_out=0, load_ready=1 immediately; next handshake produces a full clean frame.

Source files
------------

// File: rtl/reg_serializer_pkg.sv
// Shared types and helpers for the register read-out serializer.
package reg_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_serializer_bit_tick_gen.sv
// Bit-period divider: strobes in the first cycle of each serial bit and ticks in its last.
module bit_tick_gen
  import reg_serializer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_strobe,
  output logic o_tick
);

  localparam int unsigned         DIV_W    = clog2_min1(CLK_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_last;

  assign w_last   = (r_div_cnt == DIV_LAST);
  assign o_strobe = i_run && (r_div_cnt == '0);
  assign o_tick   = i_run && w_last;

  // With CLK_DIV=1 the last value is zero, so the counter never leaves 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (i_clr) begin
      r_div_cnt <= '0;
    end else if (i_run) begin
      r_div_cnt <= w_last ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/reg_serializer.sv
// Loads a WIDTH-bit word over valid/ready and shifts it out one bit per CLK_DIV cycles.
module reg_serializer
  import reg_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             bit_strobe,
  output logic             done
);

  localparam int unsigned      BIT_W    = clog2_min1(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             w_shifting;
  logic             w_clr;
  logic             w_load;
  logic             w_strobe;
  logic             w_tick;

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_clr      = !w_shifting;
  assign w_load     = (r_state == ST_IDLE) && load_valid;

  bit_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_clr),
    .i_run   (w_shifting),
    .o_strobe(w_strobe),
    .o_tick  (w_tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs decode from state and counters only; load_valid steers next state alone.
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    ser_en      = 1'b0;
    ser_out     = 1'b0;
    bit_strobe  = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_en     = 1'b1;
        ser_out    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        bit_strobe = w_strobe;
        if (w_tick && (r_bit_cnt == BIT_LAST)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= data_in;
      r_bit_cnt <= '0;
    end else if (w_shifting && w_tick) begin
      r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
      if (r_bit_cnt != BIT_LAST) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_serializer.sv
// Scoreboard bench for reg_serializer: three configurations driven side by side.
module tb_reg_serializer;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din [NDUT];
  logic        lv  [NDUT];
  logic        lr  [NDUT];
  logic        so  [NDUT];
  logic        se  [NDUT];
  logic        bs  [NDUT];
  logic        dn  [NDUT];

  logic [4:0]  q_cyc  [NDUT][$];
  logic [15:0] q_word [NDUT][$];
  logic [15:0] col    [NDUT];
  int          col_n  [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_serializer #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .data_in(din[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .ser_out(so[0]), .ser_en(se[0]), .bit_strobe(bs[0]), .done(dn[0]));

  reg_serializer #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .data_in(din[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .ser_out(so[1]), .ser_en(se[1]), .bit_strobe(bs[1]), .done(dn[1]));

  reg_serializer #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut_c (
    .CLK(clk), .RST_N(rst_n), .data_in(din[2][7:0]), .load_valid(lv[2]), .load_ready(lr[2]),
    .ser_out(so[2]), .ser_en(se[2]), .bit_strobe(bs[2]), .done(dn[2]));

  function automatic int w_of(input int k);
    return (k == 2) ? 8 : 16;
  endfunction

  function automatic int d_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit m_of(input int k);
    return (k != 1);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  // Expected per-cycle vector: {load_ready, ser_en, ser_out, bit_strobe, done}.
  task automatic mon(input int k);
    logic [4:0]  exp_c;
    logic [4:0]  act_c;
    logic [15:0] w;
    int          wd;
    int          dv;
    int          idx;
    bit          msb;
    wd  = w_of(k);
    dv  = d_of(k);
    msb = m_of(k);
    act_c = {lr[k], se[k], so[k], bs[k], dn[k]};
    if (q_cyc[k].size() > 0) exp_c = q_cyc[k].pop_front();
    else                     exp_c = 5'b10000;
    chk("cycle", k, {27'd0, act_c}, {27'd0, exp_c});
    if (se[k] && bs[k] && col_n[k] < 16) begin
      col[k][col_n[k]] = so[k];
      col_n[k]++;
    end
    if (dn[k]) begin
      chk("bitcount", k, col_n[k], wd);
      w = '0;
      for (int i = 0; i < wd && i < col_n[k]; i++) begin
        idx = msb ? (wd - 1 - i) : i;
        w[idx] = col[k][i];
      end
      chk("word_pending", k, q_word[k].size(), 1);
      if (q_word[k].size() > 0) chk("word", k, {16'd0, w}, {16'd0, q_word[k].pop_front()});
      col_n[k] = 0;
    end
    if (rst_n && exp_c[4] && lv[k]) begin
      q_word[k].push_back(din[k] & 16'((32'd1 << wd) - 1));
      for (int j = 0; j < wd * dv; j++) begin
        idx = msb ? (wd - 1 - j / dv) : (j / dv);
        q_cyc[k].push_back({1'b0, 1'b1, din[k][idx], (j % dv) == 0, 1'b0});
      end
      q_cyc[k].push_back(5'b00001);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) mon(k);
  end

  task automatic clear_model();
    for (int k = 0; k < NDUT; k++) begin
      q_cyc[k].delete();
      q_word[k].delete();
      col_n[k] = 0;
    end
  endtask

  // Returns at the falling edge where load_ready is seen high.
  task automatic wait_ready(input int k, input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (lr[k]) got = 1'b1;
    end
    chk(nm, k, {31'd0, got}, 32'd1);
  endtask

  task automatic send(input int k, input logic [15:0] d);
    din[k] = d;
    lv[k]  = 1'b1;
    wait_ready(k, "send_hs");
    @(posedge clk); #1;
    lv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    wait_ready(k, "idle_wait");
    @(posedge clk); #1;
  endtask

  task automatic rand_stream(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(k, 16'($urandom));
      if ($urandom_range(0, 1) == 1) din[k] = 16'($urandom);
      wait_idle(k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      din[k]   = '0;
      lv[k]    = 1'b0;
      col[k]   = '0;
      col_n[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    send(0, 16'hA5C3);
    wait_idle(0);
    send(1, 16'h0001);
    wait_idle(1);
    send(2, 16'h00FF);
    wait_idle(2);

    // Valid held across the frame while data changes; the second capture takes the late value.
    din[0] = 16'h1234;
    lv[0]  = 1'b1;
    wait_ready(0, "hold_hs1");
    @(posedge clk); #1;
    din[0] = 16'hBEEF;
    repeat (30) @(posedge clk);
    #1 din[0] = 16'h5A5A;
    wait_ready(0, "hold_hs2");
    @(posedge clk); #1;
    lv[0] = 1'b0;
    wait_idle(0);

    send(0, 16'hC3A5);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_en", 0, {31'd0, se[0]}, 32'd0);
    chk("rst_out", 0, {31'd0, so[0]}, 32'd0);
    chk("rst_rdy", 0, {31'd0, lr[0]}, 32'd1);
    chk("rst_done", 0, {31'd0, dn[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 16'h8001);
    wait_idle(0);

    fork
      rand_stream(0, 6);
      rand_stream(1, 6);
      rand_stream(2, 10);
    join

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("cyc_q_empty", k, q_cyc[k].size(), 0);
      chk("word_q_empty", k, q_word[k].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
